// File: rtl/consul_pkg.sv
// Shared types and codes for the Consul 260 console blocks.
// Imported by the arbiter and its round-robin picker.
package consul_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACQ = 2'd1,
    RELEASE  = 2'd2
  } state_e;

  localparam logic [6:0] CR_CODE    = 7'h0d;
  localparam logic [5:0] SHIFT_BASE = 6'b000111;

endpackage

// File: rtl/consul_arbiter_rr_pick.sv
// Round-robin priority selector.
// Picks the first requester after ptr_i, wrapping.
module rr_pick
  import consul_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  int unsigned j;

  // scan from ptr_i+1 around to ptr_i, first hit wins
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/consul_arbiter.sv
// Round-robin arbiter sharing the Consul 260 teletype.
// One output or input transaction at a time.
module consul_arbiter
  import consul_pkg::*;
#(
  parameter int              N_REQ          = 2,
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(10_000_000)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   req_out,
  input  logic [N_REQ-1:0]   req_in,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rx_data,
  output logic               busy,
  output logic               Cout,
  output logic [7:0]         stdout,
  output logic               CinReq,
  input  logic               CioAcq,
  input  logic [7:0]         stdin
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_W'(1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             cout_q, cout_d;
  logic             cinreq_q, cinreq_d;
  logic [7:0]       stdout_q, stdout_d;
  logic [7:0]       rx_q, rx_d;
  logic             is_in_q, is_in_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0] req_any;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  assign req_any = req_out | req_in;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i   (req_any),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // state, pointer, counter and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      cout_q   <= 1'b0;
      cinreq_q <= 1'b0;
      stdout_q <= '0;
      rx_q     <= '0;
      is_in_q  <= 1'b0;
      ptr_q    <= IW'(N_REQ - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cout_q   <= cout_d;
      cinreq_q <= cinreq_d;
      stdout_q <= stdout_d;
      rx_q     <= rx_d;
      is_in_q  <= is_in_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // next state: grant, wait for acq or timeout, release
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    cout_d   = cout_q;
    cinreq_d = cinreq_q;
    stdout_d = stdout_q;
    rx_d     = rx_q;
    is_in_d  = is_in_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!CioAcq && pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          ptr_d             = pick_idx;
          state_d           = WAIT_ACQ;
          // output wins when both are pending
          if (req_out[pick_idx]) begin
            is_in_d  = 1'b0;
            cout_d   = 1'b1;
            stdout_d = req_data[{pick_idx, 3'b000} +: 8];
          end else begin
            is_in_d  = 1'b1;
            cinreq_d = 1'b1;
          end
        end
      end
      WAIT_ACQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (CioAcq) begin
          cout_d   = 1'b0;
          cinreq_d = 1'b0;
          grant_d  = '0;
          ack_d    = grant_q;
          state_d  = RELEASE;
          if (is_in_q) begin
            rx_d = stdin;
          end
        end else if (cnt_q == TO_LAST) begin
          cout_d   = 1'b0;
          cinreq_d = 1'b0;
          grant_d  = '0;
          err_d    = grant_q;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!CioAcq) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rx_data = rx_q;
  assign busy    = (state_q != IDLE);
  assign Cout    = cout_q;
  assign stdout  = stdout_q;
  assign CinReq  = cinreq_q;

endmodule

// File: tb/tb_consul_arbiter.sv
// Self-checking bench for consul_arbiter.
// Vector table, corner sequences and random traffic.
module tb_consul_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           Clk;
  logic           Rst_n;
  logic [N-1:0]   req_out;
  logic [N-1:0]   req_in;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [7:0]     rx_data;
  logic           busy;
  logic           Cout;
  logic [7:0]     stdout;
  logic           CinReq;
  logic           CioAcq;
  logic [7:0]     stdin;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] prev_g = '0;

  consul_arbiter #(
    .N_REQ          (N),
    .TO_W           (24),
    .TIMEOUT_CYCLES (24'(TO))
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .req_out  (req_out),
    .req_in   (req_in),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .err      (err),
    .rx_data  (rx_data),
    .busy     (busy),
    .Cout     (Cout),
    .stdout   (stdout),
    .CinReq   (CinReq),
    .CioAcq   (CioAcq),
    .stdin    (stdin)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // invariants on every cycle
  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("onehot0", 32'($onehot0(grant)), 1);
      chk("ack_and_err", 32'(ack & err), 0);
      chk("resp_idx", 32'((ack | err) & ~prev_g), 0);
      chk("cout_cin", 32'(Cout & CinReq), 0);
    end
    prev_g = Rst_n ? grant : '0;
  end

  task automatic do_reset();
    Rst_n    = 1'b0;
    req_out  = '0;
    req_in   = '0;
    req_data = '0;
    CioAcq   = 1'b0;
    stdin    = '0;
    repeat (2) @(negedge Clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ackerr", 32'({ack, err}), 0);
    chk("rst_cout", 32'({Cout, CinReq, busy}), 0);
    chk("rst_data", 32'({stdout, rx_data}), 0);
    Rst_n = 1'b1;
  endtask

  // one transaction; called at a negedge with requests applied
  task automatic do_txn(input string nm, input int d,
                        input logic [7:0] sin, input logic [N-1:0] eg,
                        input bit ein, input logic [7:0] eso,
                        input bit eack, input int elat,
                        input bit drop, input int hold);
    int w;
    int c;
    int ec;
    int idx;
    w = 0;
    idx = 0;
    for (int i = 0; i < N; i++) if (eg[i]) idx = i;
    while (grant == '0 && w < 8) begin
      @(negedge Clk);
      w++;
    end
    chk({nm, ":grant"}, 32'(grant), 32'(eg));
    if (grant == '0) return;
    if (elat >= 0) chk({nm, ":lat"}, w, elat);
    chk({nm, ":cout"}, 32'(Cout), 32'(!ein));
    chk({nm, ":cinreq"}, 32'(CinReq), 32'(ein));
    if (!ein) chk({nm, ":stdout"}, 32'(stdout), 32'(eso));
    if (drop) begin
      if (ein) req_in[idx] = 1'b0;
      else req_out[idx] = 1'b0;
      req_data[8*idx +: 8] = 8'($urandom);
    end
    stdin = sin;
    ec = eack ? d + 1 : TO;
    c = 0;
    while (c < 40) begin
      if (eack && c == d) CioAcq = 1'b1;
      @(negedge Clk);
      c++;
      if ((ack | err) != '0) break;
      if (!ein) chk({nm, ":hold_so"}, 32'(stdout), 32'(eso));
      chk({nm, ":wait_cin"}, 32'({Cout, CinReq}), 32'({!ein, ein}));
    end
    chk({nm, ":done_cyc"}, c, ec);
    chk({nm, ":ack"}, 32'(ack), eack ? 32'(eg) : 0);
    chk({nm, ":err"}, 32'(err), eack ? 0 : 32'(eg));
    chk({nm, ":drop"}, 32'({Cout, CinReq, grant}), 0);
    stdin = ~sin;
    if (eack) begin
      repeat (hold) begin
        @(negedge Clk);
        chk({nm, ":no_regrant"}, 32'(grant), 0);
        chk({nm, ":pulse"}, 32'(ack | err), 0);
      end
      CioAcq = 1'b0;
    end
    if (ein && eack) chk({nm, ":rx"}, 32'(rx_data), 32'(sin));
  endtask

  typedef struct {
    string        nm;
    logic [N-1:0] ro;
    logic [N-1:0] ri;
    logic [7:0]   d0;
    logic [7:0]   d1;
    logic [7:0]   sin;
    int           dly;
    logic [N-1:0] eg;
    bit           ein;
    logic [7:0]   eso;
    bit           eack;
  } vec_t;

  vec_t vt[7];

  bit         po[N];
  bit         pi[N];
  logic [7:0] od[N];
  int         last;

  initial begin
    vt[0] = '{"out0",    2'b01, 2'b00, 8'h41, 8'h00, 8'h00,  5, 2'b01, 0, 8'h41, 1};
    vt[1] = '{"in1",     2'b00, 2'b10, 8'h00, 8'h00, 8'hC5,  3, 2'b10, 1, 8'h00, 1};
    vt[2] = '{"tmo0",    2'b01, 2'b00, 8'h5A, 8'h00, 8'h00, 20, 2'b01, 0, 8'h5A, 0};
    vt[3] = '{"both_rr", 2'b11, 2'b00, 8'h31, 8'h32, 8'h00,  0, 2'b01, 0, 8'h31, 1};
    vt[4] = '{"edge_in", 2'b10, 2'b01, 8'h00, 8'h99, 8'h7E, 15, 2'b01, 1, 8'h00, 1};
    vt[5] = '{"tmo1",    2'b10, 2'b00, 8'h00, 8'h99, 8'h00, 16, 2'b10, 0, 8'h99, 0};
    vt[6] = '{"outwin",  2'b01, 2'b01, 8'hA5, 8'h00, 8'h00,  1, 2'b01, 0, 8'hA5, 1};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      req_out  = vt[v].ro;
      req_in   = vt[v].ri;
      req_data = {vt[v].d1, vt[v].d0};
      do_txn(vt[v].nm, vt[v].dly, vt[v].sin, vt[v].eg, vt[v].ein,
             vt[v].eso, vt[v].eack, 1, 0, 3);
      req_out = '0;
      req_in  = '0;
      CioAcq  = 1'b0;
    end

    // continuous requests alternate between requesters
    do_reset();
    req_out  = 2'b11;
    req_data = {8'h32, 8'h31};
    for (int t = 0; t < 4; t++) begin
      do_txn("alt", 2, 8'h00, (t % 2 == 0) ? 2'b01 : 2'b10, 0,
             (t % 2 == 0) ? 8'h31 : 8'h32, 1, -1, 0, 1);
    end
    req_out = '0;

    // out then other requester then deferred input
    do_reset();
    req_out  = 2'b11;
    req_in   = 2'b01;
    req_data = {8'hB2, 8'hA1};
    do_txn("seq_o0", 1, 8'h00, 2'b01, 0, 8'hA1, 1, 1, 0, 1);
    req_out[0] = 1'b0;
    do_txn("seq_o1", 1, 8'h00, 2'b10, 0, 8'hB2, 1, -1, 0, 1);
    req_out[1] = 1'b0;
    do_txn("seq_i0", 4, 8'h3C, 2'b01, 1, 8'h00, 1, -1, 0, 1);
    req_in = '0;

    // reset in the middle of a wait
    do_reset();
    req_out  = 2'b01;
    req_data = {8'h00, 8'h66};
    @(negedge Clk);
    chk("mid_grant", 32'(grant), 1);
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({Cout, CinReq, grant, busy}), 0);
    chk("mid_rst_resp", 32'({ack, err}), 0);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_rst_hold", 32'({ack, err, Cout}), 0);
    Rst_n = 1'b1;
    do_txn("after_rst", 2, 8'h00, 2'b01, 0, 8'h66, 1, 1, 0, 1);
    req_out = '0;

    // random traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < N; i++) begin
      po[i] = 0;
      pi[i] = 0;
      od[i] = '0;
    end
    last = N - 1;
    for (int t = 0; t < 150; t++) begin
      int  win;
      int  d;
      bit  anyp;
      logic [7:0] sin;
      anyp = 0;
      for (int i = 0; i < N; i++) begin
        if (!po[i] && !pi[i] && ($urandom % 3 != 0)) begin
          case ($urandom % 3)
            0: po[i] = 1;
            1: pi[i] = 1;
            default: begin po[i] = 1; pi[i] = 1; end
          endcase
          od[i] = 8'($urandom);
        end
        if (po[i] || pi[i]) anyp = 1;
      end
      if (!anyp) begin
        win = $urandom % N;
        po[win] = 1;
        od[win] = 8'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        req_out[i] = po[i];
        req_in[i]  = pi[i];
        req_data[8*i +: 8] = od[i];
      end
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (win < 0 && (po[j] || pi[j])) win = j;
      end
      d   = $urandom_range(0, 18);
      sin = 8'($urandom);
      do_txn("rnd", d, sin, N'(1 << win), !po[win], od[win],
             d <= TO - 1, -1, ($urandom % 4) == 0,
             $urandom_range(1, 3));
      if (po[win]) po[win] = 0;
      else pi[win] = 0;
      req_out[win] = po[win];
      req_in[win]  = pi[win];
      last = win;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/consul_arbiter.md
Name: consul_arbiter

Overview:
- Shares the single Consul 260 teletype controller between N_REQ requesters, e.g. the CPU IO unit and the debug/boot monitor.
- Each requester may request a character output or a character input.
- The arbiter grants one transaction at a time in round-robin order and drives the consul Cout/stdout/CinReq lines.
- It returns completion, received data or a timeout error to the granted requester.
- Sits between the requesters and the consul block; Cout, stdout, CinReq, CioAcq and stdin connect port-to-port.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 24'd10_000_000, cycles in WAIT_ACQ before the transaction is aborted
TO_W, 24, timeout counter width

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
req_out  in  N_REQ  per-requester output request (level, held until ack/err)
req_in  in  N_REQ  per-requester input request (level, held until ack/err)
req_data  in  8*N_REQ  output character; slice i = req_data[8i+7:8i]; bit 7 = upper register
grant  out  N_REQ  one-hot, high for the whole granted transaction
ack  out  N_REQ  one-cycle completion pulse
err  out  N_REQ  one-cycle timeout pulse
rx_data  out  8  last received character (shared by all requesters)
busy  out  1  transaction in progress (state != IDLE)
Cout  out  1  output request to consul
stdout  out  8  character to consul
CinReq  out  1  input request to consul
CioAcq  in  1  consul completion (level)
stdin  in  8  character from consul

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. rr_ptr = N_REQ-1, so requester 0 wins first. Timeout counter = 0. Reset asserted mid-transaction drops Cout/CinReq immediately; no ack or err is issued.
- State machine (registered outputs):
  - IDLE:
    - Wait for CioAcq = 0.
    - Then select the first requester i after rr_ptr (wrapping) with req_out[i] | req_in[i].
    - If the selected requester has both requests, output wins; its input is served on a later grant.
    - Next cycle: grant[i] = 1, is_in captured, rr_ptr = i.
    - Output: stdout = slice i and Cout = 1. Input: CinReq = 1.
    - Go to WAIT_ACQ. Latency from request to Cout/CinReq is 1 cycle.
    - With no requests, remain in IDLE.
  - WAIT_ACQ:
    - The timeout counter increments each cycle.
    - stdout is held stable, independent of later changes to req_data.
    - If CioAcq = 1:
      - Next cycle: Cout/CinReq = 0, ack[i] = 1 pulse, grant = 0.
      - Input: rx_data = stdin sampled in the same cycle as CioAcq.
      - Go to RELEASE.
    - Else if counter == TIMEOUT_CYCLES-1:
      - Next cycle: Cout/CinReq = 0, err[i] = 1 pulse, grant = 0.
      - Go to RELEASE.
  - RELEASE:
    - Wait for CioAcq = 0, then clear the counter and go to IDLE.
    - This guarantees the consul has returned to idle before the next grant.
- CioAcq and the timeout in the same cycle: CioAcq wins; ack is issued, not err.
- A requester dropping its request mid-transaction has no effect; the transaction completes and ack/err is still pulsed.
- Input transactions end on CioAcq = 1, same as output.
- ack and err are never asserted together, and never for a non-granted index.
- grant is one-hot or zero.
- Round-robin fairness: with all requesters continuously requesting, grants rotate 0,1,..,N_REQ-1,0.
- busy = 1 in WAIT_ACQ and RELEASE.

Decomposition:
- Shared package consul_pkg holds:
  - the state typedef (IDLE, WAIT_ACQ, RELEASE);
  - the CR code 7'h0d;
  - the register-shift code base 6'b000111, so console blocks share the encoding.
- One sub-module, rr_pick: combinational round-robin priority selector. Inputs are the request vector and rr_ptr; outputs are the index and a valid flag.
- The FSM, timeout counter and datapath stay in consul_arbiter.

Test Plan:
1. Reset, then req_out = 2'b01 with slice0 = 8'h41. Expect:
   - grant = 01 and Cout = 1, stdout = 8'h41, one cycle later;
   - CioAcq pulsed after 5 cycles gives ack[0] one cycle later and Cout = 0;
   - no new grant until CioAcq = 0.
2. req_out = 2'b11 continuously, each transaction acked. Expect grant sequence 01,10,01,10; stdout alternates between slice0 and slice1 values (8'h31, 8'h32).
3. req_in[1] = 1 with stdin = 8'hC5 when CioAcq rises. Expect:
   - CinReq = 1 while waiting;
   - ack[1] pulse and rx_data = 8'hC5;
   - Cout stays 0 throughout.
4. Run with TIMEOUT_CYCLES = 16 and never assert CioAcq. Expect err[0] exactly 16 cycles after Cout rises, no ack, and Cout dropped in the same cycle.
5. Requester 0 has req_out and req_in both set. Expect the output is served first, then requester 1 if pending, then the input of requester 0.
6. Assert Rst_n = 0 mid-WAIT_ACQ, then release. Expect Cout = CinReq = grant = 0 immediately, no ack/err, and a new grant to requester 0 after reset.
